// File: rtl/windr2p_pkg.sv
// Shared types and constants for the wind-sensor CORDIC scheduler.
// Angles are degrees: CORDIC side Q8.10 (19 bit), result side Q8.7 (16 bit).
package windr2p_pkg;

    localparam int ANG_W = 19;
    localparam int OUT_W = 16;

    localparam logic signed [ANG_W-1:0] ANG_180_Q10 = 19'sh2D000;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        FIX,
        OUT
    } state_t;

endpackage

// File: rtl/windr2p_arb.sv
// Channel arbiter: one-hot grant plus id from req_valid.
// WR2P_RR_EN defined: round-robin from last grant + 1; otherwise lowest index wins.
module windr2p_arb
    import windr2p_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int CHW  = 2
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [N_CH-1:0] req_valid,
    input  logic            take,
    output logic [N_CH-1:0] grant,
    output logic [CHW-1:0]  grant_id,
    output logic            grant_any
);

    int             start;
    logic [CHW-1:0] idx;

`ifdef WR2P_RR_EN
    logic [CHW-1:0] rr;
    logic           rr_vld;

    // rr_vld keeps the first search after reset starting at channel 0
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr     <= '0;
            rr_vld <= 1'b0;
        end else if (take && grant_any) begin
            rr     <= grant_id;
            rr_vld <= 1'b1;
        end
    end

    always_comb start = rr_vld ? int'(rr) + 1 : 0;
`else
    logic unused_rr;
    assign unused_rr = ^{clock, reset_n, take};

    always_comb start = 0;
`endif

    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        idx       = '0;
        for (int i = 0; i < N_CH; i++) begin
            idx = CHW'((start + i) % N_CH);
            if (!grant_any && req_valid[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = idx;
                grant_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/windr2p_sched.sv
// Time-shares one rec2pol CORDIC between N_CH wind channels: arbitrate, fold X,
// run ITER iterations, quadrant-correct, emit tagged result. Macro: WR2P_RR_EN.
module windr2p_sched
    import windr2p_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int ITER = 16,
    parameter int CHW  = 2
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [N_CH-1:0]         req_valid,
    output logic [N_CH-1:0]         req_ready,
    input  logic [16*N_CH-1:0]      req_x,
    input  logic [16*N_CH-1:0]      req_y,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [CHW-1:0]          res_ch,
    output logic [OUT_W-1:0]        res_angle,
    output logic [15:0]             res_mod,
    output logic                    cdc_start,
    output logic                    cdc_enable,
    output logic [15:0]             cdc_x,
    output logic [15:0]             cdc_y,
    input  logic signed [ANG_W-1:0] cdc_angle,
    input  logic [15:0]             cdc_mod
);

    localparam int CNT_W = $clog2(ITER + 1);

    state_t                  state, state_nx;
    logic [CNT_W-1:0]        cnt;
    logic [N_CH-1:0]         grant;
    logic [CHW-1:0]          gid;
    logic                    gany;
    logic [CHW-1:0]          ch;
    logic                    x_neg, y_neg;
    logic signed [15:0]      x_sel, y_sel;
    logic signed [ANG_W-1:0] a_cor;
    logic                    unused_lsb;

    windr2p_arb #(.N_CH(N_CH), .CHW(CHW)) u_arb (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .take      (state == IDLE),
        .grant     (grant),
        .grant_id  (gid),
        .grant_any (gany)
    );

    always_comb begin
        x_sel = req_x[15:0];
        y_sel = req_y[15:0];
        for (int c = 0; c < N_CH; c++) begin
            if (gid == CHW'(c)) begin
                x_sel = req_x[16*c +: 16];
                y_sel = req_y[16*c +: 16];
            end
        end
    end

    // CORDIC only covers the right half-plane; mirror back for negative X
    always_comb begin
        a_cor = cdc_angle;
        if (x_neg)
            a_cor = y_neg ? -ANG_180_Q10 - cdc_angle : ANG_180_Q10 - cdc_angle;
    end
    assign unused_lsb = ^a_cor[2:0];

    always_comb begin
        state_nx   = state;
        req_ready  = '0;
        cdc_start  = 1'b0;
        cdc_enable = 1'b0;
        res_valid  = 1'b0;
        case (state)
            IDLE: if (gany) begin
                req_ready = grant;
                state_nx  = LOAD;
            end
            LOAD: begin
                cdc_start = 1'b1;
                state_nx  = RUN;
            end
            RUN: begin
                cdc_enable = 1'b1;
                if (cnt == CNT_W'(ITER - 1)) state_nx = FIX;
            end
            FIX: state_nx = OUT;
            OUT: begin
                res_valid = 1'b1;
                if (res_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            ch        <= '0;
            x_neg     <= 1'b0;
            y_neg     <= 1'b0;
            cdc_x     <= '0;
            cdc_y     <= '0;
            res_ch    <= '0;
            res_angle <= '0;
            res_mod   <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && gany) begin
                ch    <= gid;
                x_neg <= x_sel[15];
                y_neg <= y_sel[15];
                // -32768 has no positive counterpart in 16 bits
                cdc_x <= (x_sel == 16'sh8000) ? 16'sh7fff : (x_sel[15] ? -x_sel : x_sel);
                cdc_y <= y_sel;
            end
            if (state == RUN)
                cnt <= (cnt == CNT_W'(ITER - 1)) ? '0 : cnt + CNT_W'(1);
            if (state == FIX) begin
                res_ch    <= ch;
                res_angle <= a_cor[ANG_W-1:3];
                res_mod   <= cdc_mod;
            end
        end
    end

endmodule

// File: tb/tb_windr2p_sched.sv
// Self-checking bench for windr2p_sched with a behavioural CORDIC stand-in.
`timescale 1ns/1ps
module tb_windr2p_sched;

    localparam int  N_CH = 4;
    localparam int  ITER = 16;
    localparam int  CHW  = 2;
    localparam real PI   = 3.14159265358979;

    logic                 clock = 1'b0;
    logic                 reset_n;
    logic [N_CH-1:0]      req_valid, req_ready;
    logic [16*N_CH-1:0]   req_x, req_y;
    logic                 res_valid, res_ready;
    logic [CHW-1:0]       res_ch;
    logic [15:0]          res_angle, res_mod;
    logic                 cdc_start, cdc_enable;
    logic [15:0]          cdc_x, cdc_y;
    logic [18:0]          cdc_angle;
    logic [15:0]          cdc_mod;

    int n_tests = 0;
    int n_fail  = 0;
    int last_gnt = -1;
    longint gnt_time = 0;

    always #5 clock = ~clock;

    windr2p_sched #(.N_CH(N_CH), .ITER(ITER), .CHW(CHW)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_ch(res_ch), .res_angle(res_angle), .res_mod(res_mod),
        .cdc_start(cdc_start), .cdc_enable(cdc_enable),
        .cdc_x(cdc_x), .cdc_y(cdc_y),
        .cdc_angle(cdc_angle), .cdc_mod(cdc_mod)
    );

    function automatic int rnd(real r);
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    endfunction

    function automatic int deg_q(int x, int y, int scale);
        return rnd($atan2(real'(y), real'(x)) * 180.0 / PI * real'(scale));
    endfunction

    function automatic int hyp(int x, int y);
        int h;
        h = rnd($sqrt(real'(x) * real'(x) + real'(y) * real'(y)));
        return (h > 32767) ? 32767 : h;
    endfunction

    // CORDIC stand-in: result only valid after exactly ITER enables following start
    logic [15:0] m_x = '0, m_y = '0;
    int          m_cnt = 99;
    always @(posedge clock) begin
        if (cdc_start) begin
            m_x   <= cdc_x;
            m_y   <= cdc_y;
            m_cnt <= 0;
        end else if (cdc_enable) begin
            m_cnt <= m_cnt + 1;
        end
    end
    assign cdc_angle = (m_cnt == ITER) ? 19'(deg_q(int'($signed(m_x)), int'($signed(m_y)), 1024)) : 19'h2AAAA;
    assign cdc_mod   = (m_cnt == ITER) ? 16'(hyp(int'($signed(m_x)), int'($signed(m_y)))) : 16'h5A5A;

    // Reference arbitration from the rules: fixed lowest index, or first requester after the last grant
    function automatic int exp_grant(logic [N_CH-1:0] v);
`ifdef WR2P_RR_EN
        for (int i = 1; i <= N_CH; i++) begin
            automatic int c = (last_gnt + i + N_CH) % N_CH;
            if (v[c]) return c;
        end
`else
        for (int c = 0; c < N_CH; c++) if (v[c]) return c;
`endif
        return -1;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(string nm, int act, int exp, int tol = 0);
        n_tests++;
        if (act > exp + tol || act < exp - tol) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_ch(int c, int x, int y);
        req_x[16*c +: 16] = 16'(x);
        req_y[16*c +: 16] = 16'(y);
    endtask

    task automatic run_job(input logic [N_CH-1:0] mask, input bit keep, input int stall,
                           input string tag, output int got, output int ang, output int md);
        int eg, x, y, lat, ex_cx;
        logic [15:0] h_ang, h_mod;
        logic [CHW-1:0] h_ch;
        res_ready = (stall == 0);
        req_valid = mask;
        #1;
        eg = exp_grant(mask);
        got = -1;
        for (int c = 0; c < N_CH; c++) if (req_ready[c]) got = c;
        gnt_time = $time;
        chk({tag, " grant"}, int'(req_ready), 1 << eg);
        x = int'($signed(req_x[16*eg +: 16]));
        y = int'($signed(req_y[16*eg +: 16]));
        last_gnt = eg;
        tick();
        if (!keep) req_valid = '0;
        chk({tag, " cdc_start"}, int'(cdc_start), 1);
        ex_cx = (x == -32768) ? 32767 : ((x < 0) ? -x : x);
        chk({tag, " cdc_x"}, int'(cdc_x), ex_cx);
        chk({tag, " cdc_y"}, int'($signed(cdc_y)), y);
        lat = 1;
        while (!res_valid && lat < 100) begin
            tick();
            lat++;
        end
        chk({tag, " latency"}, lat, ITER + 3);
        ang = int'($signed(res_angle));
        md  = int'($signed(res_mod));
        chk({tag, " res_ch"}, int'(res_ch), eg);
        chk({tag, " angle"}, ang, deg_q(x, y, 128), 8);
        chk({tag, " mod"}, md, hyp(x, y), 2);
        h_ang = res_angle;
        h_mod = res_mod;
        h_ch  = res_ch;
        for (int i = 0; i < stall; i++) begin
            tick();
            chk({tag, " stall stable"}, int'(res_valid && res_angle == h_ang && res_mod == h_mod && res_ch == h_ch), 1);
            chk({tag, " stall no grant"}, int'(req_ready), 0);
        end
        res_ready = 1'b1;
        tick();
        chk({tag, " released"}, int'(res_valid), 0);
        if (keep && stall > 0) chk({tag, " idle after release"}, int'(req_ready != '0), 1);
    endtask

    typedef struct {
        int ch;
        int x;
        int y;
        int ang;
        int md;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vt[8];
        int got, ang, md, seq[5];
        longint t_prev;

        vt[0] = '{0,   1000,     0,      0, 1000};
        vt[1] = '{1,      0,  1000,  11520, 1000};
        vt[2] = '{2,  -1000,     0,  23040, 1000};
        vt[3] = '{3,  -1000,    -1, -23033, 1000};
        vt[4] = '{0, -32768,     0,  23040, 32767};
        vt[5] = '{1,   1000,  1000,   5760, 1414};
        vt[6] = '{2,  -1000,  1000,  17280, 1414};
        vt[7] = '{3,      0, -1000, -11520, 1000};

        req_valid = '0; req_x = '0; req_y = '0; res_ready = 1'b0; reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst req_ready", int'(req_ready), 0);
        chk("rst res_valid", int'(res_valid), 0);
        chk("rst res_ch", int'(res_ch), 0);
        chk("rst res_angle", int'(res_angle), 0);
        chk("rst res_mod", int'(res_mod), 0);
        chk("rst cdc_start", int'(cdc_start), 0);
        chk("rst cdc_enable", int'(cdc_enable), 0);
        chk("rst cdc_x", int'(cdc_x), 0);
        chk("rst cdc_y", int'(cdc_y), 0);
        reset_n = 1'b1;
        tick();

        foreach (vt[i]) begin
            req_x = '0; req_y = '0;
            set_ch(vt[i].ch, vt[i].x, vt[i].y);
            run_job(N_CH'(1 << vt[i].ch), 1'b0, 0, $sformatf("vec%0d", i), got, ang, md);
            chk($sformatf("vec%0d table angle", i), ang, vt[i].ang, 8);
            chk($sformatf("vec%0d table mod", i), md, vt[i].md, 2);
        end

        // nothing requested: no job may start
        repeat (3) begin
            tick();
            chk("idle no start", int'(cdc_start | cdc_enable | (req_ready != '0)), 0);
        end

        // stall 10 cycles in OUT with another request pending
        set_ch(1, 700, -300); set_ch(2, -400, 900);
        run_job(4'b0010, 1'b1, 10, "stall", got, ang, md);
        run_job(4'b0110, 1'b0, 0, "after stall", got, ang, md);

        // reset mid-RUN
        set_ch(1, 500, 300);
        req_valid = 4'b0010;
        #1;
        tick();
        req_valid = '0;
        repeat (6) tick();
        chk("pre-rst enable", int'(cdc_enable), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("midrun rst cdc_enable", int'(cdc_enable), 0);
        chk("midrun rst cdc_x", int'(cdc_x), 0);
        chk("midrun rst cdc_y", int'(cdc_y), 0);
        chk("midrun rst res_valid", int'(res_valid), 0);
        chk("midrun rst res_ch/angle/mod", int'(res_ch) | int'(res_angle) | int'(res_mod), 0);
        chk("midrun rst req_ready", int'(req_ready), 0);
        @(negedge clock);
        reset_n = 1'b1;
        last_gnt = -1;
        tick();

        // all channels requesting, res_ready high
`ifdef WR2P_RR_EN
        seq = '{0, 1, 2, 3, 0};
`else
        seq = '{0, 0, 0, 0, 0};
`endif
        set_ch(0, 1200, 50); set_ch(1, -800, 600); set_ch(2, 30, -2000); set_ch(3, -5000, -5000);
        t_prev = 0;
        for (int i = 0; i < 5; i++) begin
            run_job(4'b1111, 1'b1, 0, $sformatf("all%0d", i), got, ang, md);
            chk($sformatf("all%0d grant order", i), got, seq[i]);
            if (i > 0) chk($sformatf("all%0d throughput", i), int'((gnt_time - t_prev) / 10), ITER + 4);
            t_prev = gnt_time;
        end
        req_valid = '0;

        for (int i = 0; i < 40; i++) begin
            logic [N_CH-1:0] m;
            for (int c = 0; c < N_CH; c++) begin
                if ($urandom_range(0, 9) == 0) set_ch(c, -32768, int'($urandom_range(0, 65535)) - 32768);
                else set_ch(c, int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);
            end
            m = N_CH'($urandom_range(1, (1 << N_CH) - 1));
            run_job(m, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), $sformatf("rnd%0d", i), got, ang, md);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
